// File: rtl/sort4_pkg.sv
// Shared types and constants for the 4-word compare-exchange sequencer.
package sort4_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

    localparam int unsigned N      = 4;
    localparam int unsigned NSTEPS = 5;

    // Sorting network (0,1),(2,3),(0,2),(1,3),(1,2), packed 2 bits per step, step 0 in the LSBs.
    localparam logic [9:0] SCHED_A = {2'd1, 2'd1, 2'd0, 2'd2, 2'd0};
    localparam logic [9:0] SCHED_B = {2'd2, 2'd3, 2'd2, 2'd3, 2'd1};

endpackage

// File: rtl/sort4_sequencer_if.sv
// Input and output valid/ready streams of the 4-word sequencer.
interface sort4_sequencer_if #(parameter int DW = 8);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/cmp_exchange.sv
// Unsigned compare-exchange: lo/hi ordered outputs; equal inputs pass through unswapped.
module cmp_exchange #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] hi,
    output logic          swapped
);

    assign swapped = (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/sort4_sequencer.sv
// Loads 4 words, sorts them with one shared compare-exchange over a 5-step network, streams them out.
// Define SORT4_DESCEND_EN to drain in descending order instead of ascending.
module sort4_sequencer
    import sort4_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sort4_sequencer_if.slave     bus,
    output logic                 busy
);

    state_t        state, state_n;
    logic [1:0]    load_cnt, drain_cnt, out_idx, ia, ib;
    logic [2:0]    step;
    logic [DW-1:0] r [N];
    logic [DW-1:0] ca, cb, lo, hi;
    logic          swapped;
    logic          in_fire, out_fire;
    logic          in_ready_i, out_valid_i, out_last_i, busy_i;
    logic [DW-1:0] out_data_i;

`ifdef SORT4_DESCEND_EN
    assign out_idx = 2'd3 - drain_cnt;
`else
    assign out_idx = drain_cnt;
`endif

    always_comb begin
        ia = SCHED_A[{step, 1'b0} +: 2];
        ib = SCHED_B[{step, 1'b0} +: 2];
        ca = r[ia];
        cb = r[ib];
    end

    cmp_exchange #(.DW(DW)) u_cmp (
        .a       (ca),
        .b       (cb),
        .lo      (lo),
        .hi      (hi),
        .swapped (swapped)
    );

    assign in_fire  = bus.in_valid & in_ready_i;
    assign out_fire = out_valid_i & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        in_ready_i  = 1'b0;
        out_valid_i = 1'b0;
        out_last_i  = 1'b0;
        out_data_i  = '0;
        busy_i      = 1'b0;
        case (state)
            LOAD: begin
                in_ready_i = 1'b1;
                if (in_fire && load_cnt == 2'd3) state_n = SORT;
            end
            SORT: begin
                busy_i = 1'b1;
                if (step == 3'(NSTEPS - 1)) state_n = DRAIN;
            end
            DRAIN: begin
                busy_i      = 1'b1;
                out_valid_i = 1'b1;
                out_last_i  = (drain_cnt == 2'd3);
                out_data_i  = r[out_idx];
                if (out_fire && drain_cnt == 2'd3) state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            step      <= '0;
            drain_cnt <= '0;
            for (int unsigned i = 0; i < N; i++) r[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    step      <= '0;
                    drain_cnt <= '0;
                    if (in_fire) begin
                        r[load_cnt] <= bus.in_data;
                        load_cnt    <= (load_cnt == 2'd3) ? 2'd0 : load_cnt + 2'd1;
                    end
                end
                SORT: begin
                    if (swapped) begin
                        r[ia] <= lo;
                        r[ib] <= hi;
                    end
                    step <= (step == 3'(NSTEPS - 1)) ? 3'd0 : step + 3'd1;
                end
                DRAIN: begin
                    load_cnt <= '0;
                    if (out_fire) drain_cnt <= (drain_cnt == 2'd3) ? 2'd0 : drain_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = out_valid_i;
    assign bus.out_last  = out_last_i;
    assign bus.out_data  = out_data_i;
    assign busy          = busy_i;

endmodule

// File: tb/tb_sort4_sequencer.sv
// Scoreboard bench for sort4_sequencer: directed blocks, reset/hold/back-to-back cases, random blocks.
module tb_sort4_sequencer;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    sort4_sequencer_if #(.DW(DW)) bus();

    sort4_sequencer #(.DW(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned data;
        bit          last;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0;
    int          nerr = 0;
    int unsigned cyc = 0;
    int unsigned last_hs_cyc = 0;
    bit          rand_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain sort of the four values, optionally reversed.
    function automatic void push_expected(input int unsigned w[4]);
        int unsigned s[4];
        int unsigned t;
        exp_t e;
        for (int i = 0; i < 4; i++) s[i] = w[i];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        for (int i = 0; i < 4; i++) begin
`ifdef SORT4_DESCEND_EN
            e.data = s[3-i];
`else
            e.data = s[i];
`endif
            e.last = (i == 3);
            sb.push_back(e);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", bus.out_data, 9999);
            end else begin
                e = sb.pop_front();
                check("out_data", bus.out_data, e.data);
                check("out_last", bus.out_last, e.last);
            end
            if (bus.out_last) last_hs_cyc = cyc;
        end
    end

    task automatic step_sync();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_word(input int unsigned w, output int unsigned hs);
        bit done;
        done = 1'b0;
        hs = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w[DW-1:0];
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                hs = cyc;
                done = 1'b1;
                step_sync();
            end
        end
        if (!done) begin
            $display("FAIL in_handshake_timeout: word %0d never accepted", w);
            nerr++;
            $fatal(1, "input handshake timeout");
        end
    endtask

    task automatic send_block(input int unsigned w[4], input bit keep, input bit push,
                              input int unsigned maxgap, output int unsigned first_hs);
        int unsigned hs;
        int unsigned g;
        first_hs = 0;
        for (int i = 0; i < 4; i++) begin
            g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            if (g > 0) begin
                bus.in_valid = 1'b0;
                repeat (g) step_sync();
            end
            send_word(w[i], hs);
            if (i == 0) first_hs = hs;
        end
        if (push) push_expected(w);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.in_ready) done = 1'b1;
        end
        check("drain_done", sb.size(), 0);
        step_sync();
    endtask

    int unsigned blk[4];
    int unsigned fh;
    int unsigned lat;
    bit          seen;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last",  bus.out_last,  0);
        check("rst_busy",      busy,          0);
        check("rst_out_data",  bus.out_data,  0);
        step_sync();
        rst = 1'b0;
        step_sync();

        // Basic block with latency measurement.
        blk = '{7, 3, 9, 1};
        send_block(blk, 1'b0, 1'b1, 0, fh);
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 12 && !seen; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        check("first_out_latency", lat, 6);
        wait_drain();

        blk = '{5, 5, 2, 5};
        send_block(blk, 1'b0, 1'b1, 0, fh);
        wait_drain();

        blk = '{255, 0, 128, 127};
        send_block(blk, 1'b0, 1'b1, 0, fh);
        wait_drain();

        // Backpressure on the second output with a pending input word.
        blk = '{7, 3, 9, 1};
        send_block(blk, 1'b1, 1'b1, 0, fh);
        bus.in_data = 8'd42;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("hold_first_valid_seen", seen, 1);
        step_sync();
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 1);
`ifdef SORT4_DESCEND_EN
            check("hold_out_data",  bus.out_data,  7);
`else
            check("hold_out_data",  bus.out_data,  3);
`endif
            check("hold_out_last",  bus.out_last,  0);
            check("hold_in_ready",  bus.in_ready,  0);
            check("hold_busy",      busy,          1);
        end
        step_sync();
        bus.out_ready = 1'b1;

        // Back-to-back blocks with in_valid held high throughout.
        blk = '{42, 17, 200, 17};
        send_block(blk, 1'b1, 1'b1, 0, fh);
        check("b2b_first_load_after_last_a", fh, last_hs_cyc + 1);
        blk = '{1, 2, 3, 0};
        send_block(blk, 1'b0, 1'b1, 0, fh);
        check("b2b_first_load_after_last_b", fh, last_hs_cyc + 1);
        wait_drain();

        // Reset during SORT discards the block.
        blk = '{4, 3, 2, 1};
        send_block(blk, 1'b0, 1'b0, 0, fh);
        step_sync();
        check("sort_busy", busy, 1);
        check("sort_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        step_sync();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",  bus.in_ready,  1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy",      busy,          0);
        step_sync();
        blk = '{8, 6, 7, 5};
        send_block(blk, 1'b0, 1'b1, 0, fh);
        wait_drain();

        // Random blocks with random input gaps and output backpressure.
        fork
            begin
                int unsigned rb[4];
                for (int b = 0; b < 20; b++) begin
                    for (int i = 0; i < 4; i++) begin
                        case ($urandom_range(0, 5))
                            0:       rb[i] = 0;
                            1:       rb[i] = 255;
                            2:       rb[i] = $urandom_range(0, 3);
                            default: rb[i] = $urandom_range(0, 255);
                        endcase
                    end
                    send_block(rb, 1'($urandom_range(0, 1)), 1'b1, 2, fh);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    step_sync();
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.in_valid = 1'b0;
        wait_drain();

        @(negedge clk);
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_out_data",  bus.out_data,  0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        nerr++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "timeout");
    end

endmodule
